rf_wb_merge_3r1w: RTL and testbench

//  Merges two writeback streams into the single write port of the 32-deep 3-read/1-write register
//  RAM (fpga_ram_3r1w_32d) and forwards in-flight write data onto its three read ports.

---
 rtl/rf_wb_merge_3r1w.sv | 182 ++++++++++++++++++
 tb/tb_rf_wb_merge_3r1w.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_merge_3r1w.sv
// rf_wb_merge_3r1w
//   Merges two writeback streams into the single write port of a 32-deep
//   3-read/1-write register RAM. Each source feeds a small queue. A round-robin
//   arbiter drains one queue head per cycle into a registered write stage that
//   drives the RAM write port. The three read ports see in-flight writes
//   (write stage and queued entries) through combinational forwarding.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wbN_valid/ready          source N handshake (N = 0, 1)
//   wbN_addr, wbN_data       source N register address and write data
//   ram_wea/addrw/din        registered RAM write port
//   rd_addr0..2              read addresses (also drive the RAM read ports)
//   ram_dout0..2             raw RAM read data
//   rd_data0..2              forwarded read data
//   busy                     any queued entry or a pending RAM write
module rf_wb_merge_3r1w #(
   parameter int WIDTH    = 32,
   parameter int QDEPTH   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb0_valid,
   output logic             wb0_ready,
   input  logic [4:0]       wb0_addr,
   input  logic [WIDTH-1:0] wb0_data,
   input  logic             wb1_valid,
   output logic             wb1_ready,
   input  logic [4:0]       wb1_addr,
   input  logic [WIDTH-1:0] wb1_data,
   output logic             ram_wea,
   output logic [4:0]       ram_addrw,
   output logic [WIDTH-1:0] ram_din,
   input  logic [4:0]       rd_addr0,
   input  logic [4:0]       rd_addr1,
   input  logic [4:0]       rd_addr2,
   input  logic [WIDTH-1:0] ram_dout0,
   input  logic [WIDTH-1:0] ram_dout1,
   input  logic [WIDTH-1:0] ram_dout2,
   output logic [WIDTH-1:0] rd_data0,
   output logic [WIDTH-1:0] rd_data1,
   output logic [WIDTH-1:0] rd_data2,
   output logic             busy
);

   localparam int          PW       = $clog2(QDEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(QDEPTH);

   logic [4:0]        q_addr [2][QDEPTH];
   logic [WIDTH-1:0]  q_data [2][QDEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]       wr_ptr [2];
   logic [PW:0]       rd_ptr [2];
   logic [PW:0]       count  [2];
   logic [QDEPTH-1:0] ent_vld [2];
   logic [4:0]        head_addr [2];
   logic [WIDTH-1:0]  head_data [2];
   logic [4:0]        in_addr [2];
   logic [WIDTH-1:0]  in_data [2];
   logic [1:0]        full;
   logic [1:0]        nonempty;
   logic [1:0]        push;
   logic [1:0]        grant;
   logic [1:0]        inflight;
   logic              rr;
   logic [4:0]        raddr [3];
   logic [WIDTH-1:0]  rdout [3];
   logic [WIDTH-1:0]  fwd   [3];

   assign in_addr[0] = wb0_addr;
   assign in_addr[1] = wb1_addr;
   assign in_data[0] = wb0_data;
   assign in_data[1] = wb1_data;
   assign raddr[0]   = rd_addr0;
   assign raddr[1]   = rd_addr1;
   assign raddr[2]   = rd_addr2;
   assign rdout[0]   = ram_dout0;
   assign rdout[1]   = ram_dout1;
   assign rdout[2]   = ram_dout2;

   // ---- queue status (registered pointers only) ----
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         count[s]     = wr_ptr[s] - rd_ptr[s];
         full[s]      = (count[s] == FULL_CNT);
         nonempty[s]  = (count[s] != '0);
         head_addr[s] = q_addr[s][rd_ptr[s][PW-1:0]];
         head_data[s] = q_data[s][rd_ptr[s][PW-1:0]];
         // Slot i is live when its distance from the read pointer is below count.
         for (int i = 0; i < QDEPTH; i++) begin
            ent_vld[s][i] = ({1'b0, PW'(i) - rd_ptr[s][PW-1:0]} < count[s]);
         end
      end
   end

   // Ready never looks at this cycle's pop, so a full queue stalls one cycle.
   assign wb0_ready = !rst && !full[0];
   assign wb1_ready = !rst && !full[1];

   // Zero-register writes complete the handshake but are not stored.
   assign push = {wb1_valid && wb1_ready && !(ZERO_REG != 0 && wb1_addr == 5'd0),
                  wb0_valid && wb0_ready && !(ZERO_REG != 0 && wb0_addr == 5'd0)};

   assign grant = {nonempty[1] && (!nonempty[0] ||  rr),
                   nonempty[0] && (!nonempty[1] || !rr)};

   // ---- queue storage (data, not reset) ----
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            q_addr[s][wr_ptr[s][PW-1:0]] <= in_addr[s];
            q_data[s][wr_ptr[s][PW-1:0]] <= in_data[s];
         end
      end
   end

   // ---- pointers, arbiter and write stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            wr_ptr[s] <= '0;
            rd_ptr[s] <= '0;
         end
         rr        <= 1'b0;
         ram_wea   <= 1'b0;
         ram_addrw <= '0;
         ram_din   <= '0;
      end else begin
         for (int s = 0; s < 2; s++) begin
            if (push[s])  wr_ptr[s] <= wr_ptr[s] + 1'b1;
            if (grant[s]) rd_ptr[s] <= rd_ptr[s] + 1'b1;
         end
         ram_wea <= |grant;
         if (grant[0]) begin
            ram_addrw <= head_addr[0];
            ram_din   <= head_data[0];
            rr        <= 1'b1;
         end else if (grant[1]) begin
            ram_addrw <= head_addr[1];
            ram_din   <= head_data[1];
            rr        <= 1'b0;
         end
      end
   end

   // ---- read forwarding; later assignments win, giving the priority order ----
   always_comb begin
      for (int p = 0; p < 3; p++) begin
         fwd[p] = rdout[p];
         for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < QDEPTH; i++) begin
               if (ent_vld[s][i] && q_addr[s][i] == raddr[p]) fwd[p] = q_data[s][i];
            end
         end
         if (ram_wea && ram_addrw == raddr[p]) fwd[p] = ram_din;
         if (ZERO_REG != 0 && raddr[p] == 5'd0) fwd[p] = '0;
      end
   end

   assign rd_data0 = fwd[0];
   assign rd_data1 = fwd[1];
   assign rd_data2 = fwd[2];
   assign busy     = (|count[0]) || (|count[1]) || ram_wea;

   // Rename uniqueness: an accepted address must not already be in flight.
   always_comb begin
      inflight = '0;
      for (int s = 0; s < 2; s++) begin
         if (ram_wea && ram_addrw == in_addr[s]) inflight[s] = 1'b1;
         for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < QDEPTH; i++) begin
               if (ent_vld[t][i] && q_addr[t][i] == in_addr[s]) inflight[s] = 1'b1;
            end
         end
      end
   end

   a_unique_inflight: assert property (@(posedge clk) disable iff (rst)
      !(push[0] && inflight[0]) && !(push[1] && inflight[1]) &&
      !((&push) && wb0_addr == wb1_addr));

endmodule

// File: tb/tb_rf_wb_merge_3r1w.sv
// Bench for rf_wb_merge_3r1w: directed cycle scripts drive the two writeback
// sources; every expected RAM write is queued up front and a negedge monitor
// pops and compares whenever ram_wea is high. Forwarding, ready and busy are
// compared directly against hand-computed values.
module tb_rf_wb_merge_3r1w;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb0_valid, wb1_valid;
   logic        wb0_ready, wb1_ready;
   logic [4:0]  wb0_addr, wb1_addr;
   logic [31:0] wb0_data, wb1_data;
   logic        ram_wea;
   logic [4:0]  ram_addrw;
   logic [31:0] ram_din;
   logic [4:0]  rd_addr0, rd_addr1, rd_addr2;
   logic [31:0] ram_dout0, ram_dout1, ram_dout2;
   logic [31:0] rd_data0, rd_data1, rd_data2;
   logic        busy;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        mem_init;
   logic [31:0] mem [32];

   always #5 clk = ~clk;

   rf_wb_merge_3r1w #(.WIDTH(32), .QDEPTH(2), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
      .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
      .ram_wea(ram_wea), .ram_addrw(ram_addrw), .ram_din(ram_din),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .ram_dout0(ram_dout0), .ram_dout1(ram_dout1), .ram_dout2(ram_dout2),
      .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_data2(rd_data2),
      .busy(busy)
   );

   // RAM model: async read, write at the clock edge. Preset contents are
   // 0xEEEE0000 | addr so raw RAM data is distinguishable from forwarded data.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'hEEEE0000 | 32'(i);
      end else if (ram_wea) begin
         mem[ram_addrw] <= ram_din;
      end
   end
   assign ram_dout0 = mem[rd_addr0];
   assign ram_dout1 = mem[rd_addr1];
   assign ram_dout2 = mem[rd_addr2];

   // Scoreboard monitor
   always @(negedge clk) begin
      wr_t e;
      if (ram_wea === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL ram_write: got addr=%0d data=%h, expected no write", ram_addrw, ram_din);
         end else begin
            e = exp_q.pop_front();
            if (ram_addrw !== e.a || ram_din !== e.d) begin
               errors++;
               $display("FAIL ram_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        ram_addrw, ram_din, e.a, e.d);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) next_cycle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wb0_valid = 1'b0;
      wb1_valid = 1'b0;
      @(negedge clk);
      chk("rst_ready0", 32'(wb0_ready), 32'd0);
      chk("rst_ready1", 32'(wb1_ready), 32'd0);
      next_cycle();
      rst = 1'b0;
   endtask

   logic [5:0] exp_r0 = 6'b010111;
   logic [5:0] exp_r1 = 6'b101011;

   initial begin
      int i0, i1, n;
      logic r0, r1;
      rst = 1'b1;
      mem_init = 1'b1;
      wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
      wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
      rd_addr0 = '0; rd_addr1 = '0; rd_addr2 = '0;
      next_cycle();
      mem_init = 1'b0;
      next_cycle();
      rst = 1'b0;

      // Test 1: single write, latency and forwarding through each stage
      rd_addr0 = 5'd5;
      wb0_valid = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hA5A5A5A5;
      expect_wr(5'd5, 32'hA5A5A5A5);
      @(negedge clk);
      chk("reset_wea",   32'(ram_wea),   32'd0);
      chk("reset_addrw", 32'(ram_addrw), 32'd0);
      chk("reset_din",   ram_din,        32'd0);
      chk("reset_busy",  32'(busy),      32'd0);
      chk("t1_ready0",   32'(wb0_ready), 32'd1);
      chk("t1_rd_same_cycle", rd_data0, 32'hEEEE0005);
      next_cycle();
      wb0_valid = 1'b0;
      @(negedge clk);
      chk("t1_rd_queue", rd_data0, 32'hA5A5A5A5);
      chk("t1_wea_c1",   32'(ram_wea), 32'd0);
      chk("t1_busy_c1",  32'(busy), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("t1_wea_c2",   32'(ram_wea), 32'd1);
      chk("t1_addrw_c2", 32'(ram_addrw), 32'd5);
      chk("t1_rd_wstage", rd_data0, 32'hA5A5A5A5);
      next_cycle();
      @(negedge clk);
      chk("t1_rd_ram",  rd_data0, 32'hA5A5A5A5);
      chk("t1_wea_c3",  32'(ram_wea), 32'd0);
      chk("t1_busy_c3", 32'(busy), 32'd0);
      idle(2);

      // Test 2: both sources every cycle, alternating drain starting with src0
      do_reset();
      expect_wr(5'd1, 32'hD0000001); expect_wr(5'd5, 32'hD0000005);
      expect_wr(5'd2, 32'hD0000002); expect_wr(5'd6, 32'hD0000006);
      expect_wr(5'd3, 32'hD0000003); expect_wr(5'd7, 32'hD0000007);
      expect_wr(5'd4, 32'hD0000004); expect_wr(5'd8, 32'hD0000008);
      i0 = 0; i1 = 0; n = 0;
      while ((i0 < 4 || i1 < 4) && n < 40) begin
         wb0_valid = (i0 < 4); wb0_addr = 5'(1 + i0); wb0_data = 32'hD0000000 | 32'(1 + i0);
         wb1_valid = (i1 < 4); wb1_addr = 5'(5 + i1); wb1_data = 32'hD0000000 | 32'(5 + i1);
         @(negedge clk);
         r0 = wb0_ready;
         r1 = wb1_ready;
         if (n < 6) begin
            chk($sformatf("t2_ready0_c%0d", n), 32'(r0), 32'(exp_r0[n]));
            chk($sformatf("t2_ready1_c%0d", n), 32'(r1), 32'(exp_r1[n]));
         end
         if (wb0_valid && r0) i0++;
         if (wb1_valid && r1) i1++;
         next_cycle();
         n++;
      end
      wb0_valid = 1'b0;
      wb1_valid = 1'b0;
      chk("t2_accepted", 32'(i0 + i1), 32'd8);
      chk("t2_cycles",   32'(n), 32'd6);
      idle(6);

      // Test 3: queue0 fills while src1 holds a grant, ready returns after a pop
      do_reset();
      expect_wr(5'd10, 32'h3300000A); expect_wr(5'd20, 32'h33000014);
      expect_wr(5'd11, 32'h3300000B); expect_wr(5'd12, 32'h3300000C);
      expect_wr(5'd13, 32'h3300000D);
      wb0_valid = 1'b1; wb0_addr = 5'd10; wb0_data = 32'h3300000A;
      wb1_valid = 1'b1; wb1_addr = 5'd20; wb1_data = 32'h33000014;
      @(negedge clk); chk("t3_ready0_c0", 32'(wb0_ready), 32'd1);
      next_cycle();
      wb1_valid = 1'b0; wb0_addr = 5'd11; wb0_data = 32'h3300000B;
      @(negedge clk); chk("t3_ready0_c1", 32'(wb0_ready), 32'd1);
      next_cycle();
      wb0_addr = 5'd12; wb0_data = 32'h3300000C;
      @(negedge clk); chk("t3_ready0_c2", 32'(wb0_ready), 32'd1);
      next_cycle();
      wb0_addr = 5'd13; wb0_data = 32'h3300000D;
      @(negedge clk); chk("t3_ready0_full", 32'(wb0_ready), 32'd0);
      next_cycle();
      @(negedge clk); chk("t3_ready0_after_pop", 32'(wb0_ready), 32'd1);
      next_cycle();
      wb0_valid = 1'b0;
      idle(5);

      // Test 4: zero-register write is dropped, reads of r0 return zero
      do_reset();
      rd_addr1 = 5'd0;
      wb0_valid = 1'b1; wb0_addr = 5'd0; wb0_data = 32'hFFFFFFFF;
      @(negedge clk);
      chk("t4_ready0", 32'(wb0_ready), 32'd1);
      chk("t4_rd_zero_c0", rd_data1, 32'd0);
      next_cycle();
      wb0_valid = 1'b0;
      @(negedge clk);
      chk("t4_rd_zero_c1", rd_data1, 32'd0);
      chk("t4_busy_c1", 32'(busy), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("t4_wea_c2", 32'(ram_wea), 32'd0);
      chk("t4_rd_zero_c2", rd_data1, 32'd0);
      idle(2);

      // Test 5: reset with three queued entries discards them
      do_reset();
      expect_wr(5'd14, 32'h5500000E);
      wb0_valid = 1'b1; wb0_addr = 5'd14; wb0_data = 32'h5500000E;
      wb1_valid = 1'b1; wb1_addr = 5'd24; wb1_data = 32'h55000018;
      next_cycle();
      wb0_addr = 5'd15; wb0_data = 32'h5500000F;
      wb1_addr = 5'd25; wb1_data = 32'h55000019;
      next_cycle();
      wb0_valid = 1'b0; wb1_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_ready0_rst", 32'(wb0_ready), 32'd0);
      chk("t5_ready1_rst", 32'(wb1_ready), 32'd0);
      chk("t5_busy_pre",   32'(busy), 32'd1);
      next_cycle();
      rst = 1'b0;
      rd_addr0 = 5'd15; rd_addr1 = 5'd24; rd_addr2 = 5'd25;
      @(negedge clk);
      chk("t5_busy",  32'(busy), 32'd0);
      chk("t5_wea",   32'(ram_wea), 32'd0);
      chk("t5_addrw", 32'(ram_addrw), 32'd0);
      chk("t5_din",   ram_din, 32'd0);
      chk("t5_rd0_raw", rd_data0, 32'hEEEE000F);
      chk("t5_rd1_raw", rd_data1, 32'hEEEE0018);
      chk("t5_rd2_raw", rd_data2, 32'hEEEE0019);
      idle(3);
      @(negedge clk);
      chk("t5_busy_later", 32'(busy), 32'd0);
      chk("t5_rd1_later", rd_data1, 32'hEEEE0018);
      next_cycle();

      // Test 6: read addr 9 through queue1, write stage and RAM
      do_reset();
      rd_addr1 = 5'd9;
      expect_wr(5'd9, 32'h99990009);
      wb1_valid = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h99990009;
      @(negedge clk);
      chk("t6_rd_before", rd_data1, 32'hEEEE0009);
      next_cycle();
      wb1_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         chk($sformatf("t6_rd_c%0d", c), rd_data1, 32'h99990009);
         next_cycle();
      end

      idle(3);
      chk("drain_expected_writes", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
